// File: rtl/weight_bram_sequencer.sv
// Weight BRAM sequencer: shares one single-port weight BRAM between a host
// reload stream and a compute read pass feeding the neuron MAC.
module weight_bram_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic          LOAD_START,
    input  logic          LD_VALID,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_READY,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO,
    output logic          W_VALID,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_IDX,
    output logic          W_LAST,
    input  logic          W_READY,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic [DW-1:0] bram_di_q, bram_di_d;
    logic          bram_en_q, bram_en_d;
    logic          bram_we_q, bram_we_d;
    logic          done_q, done_d;

    // Two-entry output buffer; slot 0 is always the head.
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [AW-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
    logic          last0_q, last0_d, last1_q, last1_d;

    logic          rd_inflight;
    logic          pop;
    logic          push;
    logic          issue_ok;
    logic          push_slot0;

    // A read issued at the last edge returns on BRAM_DO at this edge.
    assign rd_inflight = bram_en_q & ~bram_we_q;
    assign push        = rd_inflight;
    assign pop         = (occ_q != 2'd0) & W_READY;
    assign issue_ok    = ({1'b0, occ_q} + {2'b00, rd_inflight})
                         < (3'd2 + {2'b00, pop});
    assign push_slot0  = (occ_q == 2'd0) | ((occ_q == 2'd1) & pop);

    // Next-state, counters and registered BRAM command.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        bram_addr_d = bram_addr_q;
        bram_di_d   = bram_di_q;
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (LOAD_START) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end else if (START) begin
                    // Issue address 0 on entry so data lands one edge later.
                    bram_en_d   = 1'b1;
                    bram_addr_d = '0;
                    if (LAST_IDX == '0) begin
                        rcnt_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        rcnt_d  = AW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = wcnt_q;
                    bram_di_d   = LD_DATA;
                    if (wcnt_q == LAST_IDX) begin
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end
            end
            S_READ: begin
                if (issue_ok) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = rcnt_q;
                    if (rcnt_q == LAST_IDX) begin
                        rcnt_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        rcnt_d = rcnt_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last0_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output buffer: pop shifts slot 1 forward, capture fills the first free slot.
    always_comb begin
        data0_d = data0_q;
        idx0_d  = idx0_q;
        last0_d = last0_q;
        data1_d = data1_q;
        idx1_d  = idx1_q;
        last1_d = last1_q;
        if (pop) begin
            data0_d = data1_q;
            idx0_d  = idx1_q;
            last0_d = last1_q;
        end
        if (push) begin
            if (push_slot0) begin
                data0_d = BRAM_DO;
                idx0_d  = bram_addr_q;
                last0_d = (bram_addr_q == LAST_IDX);
            end else begin
                data1_d = BRAM_DO;
                idx1_d  = bram_addr_q;
                last1_d = (bram_addr_q == LAST_IDX);
            end
        end
        occ_d = 2'(occ_q + {1'b0, push} - {1'b0, pop});
    end

    // Control state and BRAM command registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            bram_addr_q <= '0;
            bram_di_q   <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            bram_addr_q <= bram_addr_d;
            bram_di_q   <= bram_di_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            done_q      <= done_d;
        end
    end

    // Output buffer registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            idx0_q  <= '0;
            last0_q <= 1'b0;
            data1_q <= '0;
            idx1_q  <= '0;
            last1_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            data0_q <= data0_d;
            idx0_q  <= idx0_d;
            last0_q <= last0_d;
            data1_q <= data1_d;
            idx1_q  <= idx1_d;
            last1_q <= last1_d;
        end
    end

    assign LD_READY  = (state_q == S_LOAD);
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_DI   = bram_di_q;
    assign BRAM_EN   = bram_en_q;
    assign BRAM_WE   = bram_we_q;
    assign W_VALID   = (occ_q != 2'd0);
    assign W_DATA    = data0_q;
    assign W_IDX     = idx0_q;
    assign W_LAST    = (occ_q != 2'd0) & last0_q;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Testbench for weight_bram_sequencer: scoreboarded load/read passes,
// backpressure, request arbitration, mid-pass reset and a DEPTH=1 instance.
module tb_weight_bram_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0, load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic          bram_en, bram_we;
    logic [DW-1:0] bram_do = '0;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_idx;
    logic          w_last;
    logic          w_ready = 1'b0;
    logic          busy, done;

    logic          start_1 = 1'b0, load_start_1 = 1'b0;
    logic          ld_valid_1 = 1'b0;
    logic [DW-1:0] ld_data_1 = '0;
    logic          ld_ready_1;
    logic [AW-1:0] bram_addr_1;
    logic [DW-1:0] bram_di_1;
    logic          bram_en_1, bram_we_1;
    logic [DW-1:0] bram_do_1 = '0;
    logic          w_valid_1;
    logic [DW-1:0] w_data_1;
    logic [AW-1:0] w_idx_1;
    logic          w_last_1;
    logic          w_ready_1 = 1'b0;
    logic          busy_1, done_1;

    always #5 clk = ~clk;

    weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
        .CLK(clk), .RSTN(rstn), .START(start), .LOAD_START(load_start),
        .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_READY(ld_ready),
        .BRAM_ADDR(bram_addr), .BRAM_DI(bram_di), .BRAM_EN(bram_en),
        .BRAM_WE(bram_we), .BRAM_DO(bram_do), .W_VALID(w_valid),
        .W_DATA(w_data), .W_IDX(w_idx), .W_LAST(w_last),
        .W_READY(w_ready), .BUSY(busy), .DONE(done)
    );

    weight_bram_sequencer #(.DEPTH(1), .AW(AW), .DW(DW)) u_dut1 (
        .CLK(clk), .RSTN(rstn), .START(start_1), .LOAD_START(load_start_1),
        .LD_VALID(ld_valid_1), .LD_DATA(ld_data_1), .LD_READY(ld_ready_1),
        .BRAM_ADDR(bram_addr_1), .BRAM_DI(bram_di_1), .BRAM_EN(bram_en_1),
        .BRAM_WE(bram_we_1), .BRAM_DO(bram_do_1), .W_VALID(w_valid_1),
        .W_DATA(w_data_1), .W_IDX(w_idx_1), .W_LAST(w_last_1),
        .W_READY(w_ready_1), .BUSY(busy_1), .DONE(done_1)
    );

    // BRAM models: negedge access, DO held unless a read happens.
    logic [DW-1:0] mem  [2**AW];
    logic [DW-1:0] mem1 [2**AW];
    always @(negedge clk) begin
        if (bram_en === 1'b1) begin
            if (bram_we === 1'b1) mem[bram_addr] <= bram_di;
            else bram_do <= mem[bram_addr];
        end
        if (bram_en_1 === 1'b1) begin
            if (bram_we_1 === 1'b1) mem1[bram_addr_1] <= bram_di_1;
            else bram_do_1 <= mem1[bram_addr_1];
        end
    end

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    beat_t exp_q[$];
    wr_t   wr_q[$];
    int    n_pass = 0, n_total = 0;
    int    beats_seen = 0, done_cnt = 0, wr_seen = 0, rd_issues = 0;
    logic  hold_pend = 1'b0;
    beat_t hold_val;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and write.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rstn && hold_pend)
            chk("hold_stable",
                32'({w_valid, w_idx, w_data, w_last}),
                32'({1'b1, hold_val}));
        hold_pend = rstn && (w_valid === 1'b1) && (w_ready === 1'b0);
        hold_val  = '{idx: w_idx, data: w_data, last: w_last};
        if (w_valid === 1'b1 && w_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", 32'(w_idx), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("w_idx", 32'(w_idx), 32'(e.idx));
                chk("w_data", 32'(w_data), 32'(e.data));
                chk("w_last", 32'(w_last), 32'(e.last));
            end
            beats_seen++;
        end
        if (bram_en === 1'b1 && bram_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(bram_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", 32'(bram_addr), 32'(w.addr));
                chk("wr_data", 32'(bram_di), 32'(w.data));
            end
            wr_seen++;
        end
        if (bram_en === 1'b1 && bram_we === 1'b0) rd_issues++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pass();
        for (int i = 0; i < DEPTH; i++)
            exp_q.push_back('{idx: AW'(i), data: DW'(16'h0100 + i),
                              last: (i == DEPTH - 1)});
    endtask

    task automatic read_nostall();
        int n;
        push_pass();
        w_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_valid_t0", 32'(w_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_t1", 32'(w_valid), 32'd1);
        n = 1;
        for (int k = 1; k < DEPTH; k++) begin
            @(negedge clk);
            if (w_valid === 1'b1) n++;
        end
        chk("consec_beats", 32'(n), 32'(DEPTH));
        @(negedge clk);
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, b0, r0;

        // Reset state.
        #3 rstn = 1'b0;
        #1;
        chk("rst_outs",
            32'({w_valid, bram_en, bram_we, ld_ready, busy, done, w_last}),
            32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(2);

        // Load, requested together with START: load must win.
        d0 = done_cnt;
        w0 = wr_seen;
        r0 = rd_issues;
        start = 1'b1;
        load_start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        chk("load_entered", 32'({busy, ld_ready}), 32'b11);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data = DW'(16'h0100 + i);
            wr_q.push_back('{addr: AW'(i), data: ld_data});
            if (i == 5) start = 1'b1;
            @(negedge clk);
            chk("ld_ready", 32'(ld_ready), 32'd1);
            @(posedge clk); #1;
            ld_valid = 1'b0;
            start = 1'b0;
            if (i == DEPTH - 1) begin
                @(negedge clk);
                chk("ld_done", 32'({done, busy, ld_ready}), 32'b100);
            end
            @(posedge clk); #1;
        end
        chk("ld_writes", 32'(wr_seen - w0), 32'(DEPTH));
        cyc(10);
        chk("ld_done_once", 32'(done_cnt - d0), 32'd1);
        chk("no_queued_read", 32'(rd_issues - r0), 32'd0);
        chk("idle_after_load", 32'({busy, w_valid}), 32'd0);

        // Read pass with W_READY held high.
        d0 = done_cnt;
        read_nostall();
        cyc(2);
        chk("rd_done_once", 32'(done_cnt - d0), 32'd1);

        // Backpressure: random ready plus one 10-cycle stall.
        d0 = done_cnt;
        b0 = beats_seen;
        push_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cy = 0; cy < 600 && done_cnt == d0; cy++) begin
            if (cy >= 6 && cy < 16) w_ready = 1'b0;
            else w_ready = 1'($urandom_range(0, 1));
            if (cy >= 10 && cy < 16) begin
                @(negedge clk);
                chk("stall_no_issue", 32'({bram_en, w_valid}), 32'b01);
            end
            @(posedge clk); #1;
        end
        w_ready = 1'b1;
        cyc(2);
        chk("bp_done", 32'(done_cnt - d0), 32'd1);
        chk("bp_beats", 32'(beats_seen - b0), 32'(DEPTH));
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a read pass.
        d0 = done_cnt;
        b0 = beats_seen;
        push_pass();
        w_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cy = 0; cy < 100 && (beats_seen - b0) < 11; cy++) begin
            @(negedge clk); #1;
        end
        chk("mid_beats", 32'(beats_seen - b0), 32'd11);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ctl",
            32'({w_valid, w_last, bram_en, bram_we, ld_ready, busy, done}),
            32'd0);
        chk("mid_rst_data", 32'({w_data, bram_di}), 32'd0);
        chk("mid_rst_addr", 32'({w_idx, bram_addr}), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(5);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        read_nostall();

        // DEPTH=1 instance: one write, then a single last beat.
        load_start_1 = 1'b1;
        @(posedge clk); #1;
        load_start_1 = 1'b0;
        ld_valid_1 = 1'b1;
        ld_data_1 = 16'hABCD;
        @(negedge clk);
        chk("d1_ld_ready", 32'(ld_ready_1), 32'd1);
        @(posedge clk); #1;
        ld_valid_1 = 1'b0;
        @(negedge clk);
        chk("d1_ld_done", 32'({done_1, busy_1, ld_ready_1}), 32'b100);
        chk("d1_wr", 32'({bram_en_1, bram_we_1, bram_addr_1, bram_di_1}),
            32'({2'b11, 5'd0, 16'hABCD}));
        @(posedge clk); #1;
        w_ready_1 = 1'b1;
        start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        @(negedge clk);
        chk("d1_valid_t0", 32'(w_valid_1), 32'd0);
        @(negedge clk);
        chk("d1_beat", 32'({w_valid_1, w_last_1, w_idx_1, w_data_1}),
            32'({2'b11, 5'd0, 16'hABCD}));
        @(negedge clk);
        chk("d1_done", 32'({done_1, w_valid_1, busy_1}), 32'b100);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
